conv_mac_pipe: RTL and testbench
================================

Name: conv_mac_pipe

Overview:
- Parametrised, pipelined successor to the combinational 3-channel 3x3 convolution core.
- Per beat, takes CH lanes of 3x3 signed data and weight windows.
- Two modes:
  - Depthwise: one result per lane.
  - Standard: one result summed across lanes, accumulated over multiple beats (input-channel groups).
- Adds a valid/ready handshake, round-to-nearest, saturation and an accumulation window. Sits between the line-buffer/window feeder and the output writeback in the MobileNet datapath.

Parameters:
- CH, 3, number of parallel lanes (input channels per beat).
- DATA_W, 10, signed width of data, weight and output samples.
- FRAC_W, 9, fractional bits dropped when rescaling the product sum; must be 1..2*DATA_W-2.
- ACC_W, 26, signed accumulator width; must be at least 2*DATA_W+ceil(log2(9*CH)).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat this cycle.
- i_busData  in  CH*9*DATA_W  lane l, tap t at bits [(l*9+t)*DATA_W +: DATA_W], signed.
- i_busWeight  in  CH*9*DATA_W  same layout as i_busData.
- i_opcode  in  1  0 = standard conv, 1 = depthwise; sampled with the beat.
- i_first  in  1  standard mode: beat starts a new accumulation window.
- i_last  in  1  standard mode: beat closes the window and emits a result.
- o_valid  out  1  output result valid.
- i_ready  in  1  downstream accepts the result.
- o_data  out  CH*DATA_W  lane l at [l*DATA_W +: DATA_W], signed.

Behaviour:
- One clock (i_clk); reset is asynchronous and active-low on i_rst_n.
- Reset values:
  - All pipeline valid bits = 0.
  - Accumulator = 0.
  - o_valid = 0, o_data = 0.
  - o_ready = 1 one cycle after reset release.
- Handshake:
  - A beat transfers when i_valid && o_ready.
  - A result transfers when o_valid && i_ready.
  - Pipeline advance enable en = !o_valid || i_ready; o_ready = en, combinational.
  - While o_valid=1 and i_ready=0: o_data is held stable and nothing advances.
- Pipeline, 4 stages; latency from accepted beat to o_valid = 4 cycles when unstalled; throughput 1 beat/cycle.
  - S1: register 9*CH signed products, each 2*DATA_W wide.
  - S2: per-lane adder tree; register per-lane sums, sign-extended to ACC_W.
  - S3, depthwise: pass the per-lane sums through.
  - S3, standard: s = sum over lanes. If i_first: acc = s; else: acc = acc + s (wraps modulo 2^ACC_W). The beat is marked result-bearing only if i_last.
  - S4: for each result value v, r = (v + 2^(FRAC_W-1)) >>> FRAC_W (arithmetic shift), then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Register into o_data and set o_valid.
- Standard-mode output: lane 0 holds the result; lanes 1..CH-1 are 0.
- Depthwise:
  - i_first/i_last are ignored; every beat emits one result.
  - The accumulator is untouched.
- Standard non-last beats produce no o_valid.
- Boundaries:
  - i_first && i_last on the same beat is a single-beat window.
  - A beat without i_first after reset accumulates onto 0.
  - i_opcode may change between beats; an in-flight window is not flushed and the accumulator simply persists.
  - Reset mid-window discards the partial sum and all in-flight beats.

Optional Feature:
- CONV_RELU_EN defined: S4 clamps negative results to 0 after saturation, giving an output range of [0, 2^(DATA_W-1)-1].
- Undefined: signed output, no clamp.

Decomposition:
- Shared package conv_pkg holds:
  - OPC_STD=1'b0, OPC_DW=1'b1.
  - KERN_TAPS=9.
  - Rounding/saturation helper function sat_round(value, FRAC_W, DATA_W).
- One sub-module, conv_lane_mac: a single lane's 9 multipliers plus adder tree, covering S1–S2, instantiated CH times.

Test Plan:
- Depthwise, i_ready=1. Lane0 tap0 256*256, lane1 tap0 -256*256, lane2 all 0, other taps 0 -> 4 cycles later o_data = {0, -128, 128}, one o_valid pulse.
- Standard, single beat with first=last=1. Each lane tap0 = 256*256 -> lane0 = 384 (196608>>9), lanes 1–2 = 0.
- Saturation:
  - All 27 taps 511*511, standard -> 511.
  - All taps data -512, weight 511 -> -512.
  - Same negative case with CONV_RELU_EN -> 0.
- Accumulation window of 3 beats (first, mid, last). Each beat lane0 tap0 = 128*256, rest 0 -> a single o_valid with lane0 = 192; no output on beats 1–2.
- Backpressure: stream 8 depthwise beats with i_ready low for 5 cycles mid-stream -> o_data stable while stalled, o_ready=0 when full, all 8 results in order with no loss or duplication.
- Reset mid-window: after the first beat, pulse i_rst_n low. Expect o_valid=0 and o_data=0 immediately. Then a beat with first=0, last=1 and lane0 tap0 = 256*256 -> result 128.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, types and the rounding/saturation helper for
// the pipelined convolution MAC (conv_mac_pipe and conv_lane_mac).
//   OPC_STD / OPC_DW : opcode encodings (standard conv / depthwise)
//   KERN_TAPS        : taps per 3x3 window
//   beat_ctl_t       : per-beat control carried alongside the pipeline
//   sat_round()      : round-to-nearest, drop frac_w bits, saturate to data_w
package conv_pkg;

  localparam logic OPC_STD   = 1'b0;
  localparam logic OPC_DW    = 1'b1;
  localparam int   KERN_TAPS = 9;

  // Working width of sat_round; wide enough for any legal ACC_W.
  localparam int   SR_W      = 64;

  typedef struct packed {
    logic opc;
    logic first;
    logic last;
  } beat_ctl_t;

  // Adds half an LSB of the retained result, arithmetic-shifts away frac_w
  // bits, then clamps to the signed data_w range. The result is returned
  // sign-extended to SR_W; callers keep the low data_w bits.
  function automatic logic signed [SR_W-1:0] sat_round(
    input logic signed [SR_W-1:0] value,
    input int                     frac_w,
    input int                     data_w
  );
    logic signed [SR_W-1:0] half;
    logic signed [SR_W-1:0] r;
    logic signed [SR_W-1:0] hi;
    logic signed [SR_W-1:0] lo;
    half = 64'sd1 <<< (frac_w - 1);
    r    = (value + half) >>> frac_w;
    hi   = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (data_w - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/conv_lane_mac.sv
// conv_lane_mac: one lane of the convolution MAC, pipeline stages S1-S2.
//   S1 registers the 9 signed products (2*DATA_W each), S2 registers their
//   sum sign-extended to ACC_W. Both stages advance only when i_en is high.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : pipeline advance enable
//   i_data         : 9 signed taps, tap t at [t*DATA_W +: DATA_W]
//   i_weight       : 9 signed weights, same layout
//   o_sum          : registered lane dot product, ACC_W signed
module conv_lane_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int ACC_W  = 26
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic [KERN_TAPS*DATA_W-1:0]   i_data,
  input  logic [KERN_TAPS*DATA_W-1:0]   i_weight,
  output logic signed [ACC_W-1:0]       o_sum
);

  logic signed [2*DATA_W-1:0] prod_q [KERN_TAPS];
  logic signed [ACC_W-1:0]    sum_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int t = 0; t < KERN_TAPS; t++) prod_q[t] <= '0;
    end else if (i_en) begin
      for (int t = 0; t < KERN_TAPS; t++) begin
        prod_q[t] <= $signed(i_data[t*DATA_W +: DATA_W]) *
                     $signed(i_weight[t*DATA_W +: DATA_W]);
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int t = 0; t < KERN_TAPS; t++) sum_c = sum_c + ACC_W'(prod_q[t]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  o_sum <= '0;
    else if (i_en) o_sum <= sum_c;
  end

endmodule

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: 4-stage pipelined CH-lane 3x3 convolution MAC with
// valid/ready handshake, depthwise and standard (accumulating) modes,
// round-to-nearest and saturation.
//   S1-S2 : per-lane products and adder tree (conv_lane_mac x CH)
//   S3    : depthwise pass-through, or cross-lane sum into the window accumulator
//   S4    : sat_round per result lane, registered into o_data / o_valid
// Build option: define CONV_RELU_EN to clamp negative results to 0 in S4.
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_valid / o_ready       : input beat handshake (o_ready is combinational)
//   i_busData, i_busWeight  : lane l tap t at [(l*9+t)*DATA_W +: DATA_W]
//   i_opcode                : 0 standard, 1 depthwise
//   i_first / i_last        : standard-mode window open / close
//   o_valid / i_ready       : result handshake
//   o_data                  : lane l at [l*DATA_W +: DATA_W]
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int CH     = 3,
  parameter int DATA_W = 10,
  parameter int FRAC_W = 9,
  parameter int ACC_W  = 26
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [CH*KERN_TAPS*DATA_W-1:0]    i_busData,
  input  logic [CH*KERN_TAPS*DATA_W-1:0]    i_busWeight,
  input  logic                              i_opcode,
  input  logic                              i_first,
  input  logic                              i_last,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [CH*DATA_W-1:0]              o_data
);

  logic                    en;
  logic                    v1_q, v2_q, v3_q;
  beat_ctl_t               ctl1_q, ctl2_q;
  logic signed [ACC_W-1:0] lane_sum [CH];
  logic signed [ACC_W-1:0] res3_q   [CH];
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] std_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [SR_W-1:0]  res_wide [CH];
  logic [CH-1:0]           rnd_unused;

  // The whole pipe stalls only when a result is held for a busy consumer.
  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  for (genvar l = 0; l < CH; l++) begin : g_lane
    conv_lane_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (en),
      .i_data   (i_busData  [l*KERN_TAPS*DATA_W +: KERN_TAPS*DATA_W]),
      .i_weight (i_busWeight[l*KERN_TAPS*DATA_W +: KERN_TAPS*DATA_W]),
      .o_sum    (lane_sum[l])
    );
    // Upper bits of the saturated value are pure sign extension.
    assign rnd_unused[l] = ^res_wide[l][SR_W-1:DATA_W];
  end

  always_comb begin
    std_sum = '0;
    for (int l = 0; l < CH; l++) std_sum = std_sum + lane_sum[l];
    acc_next = ctl2_q.first ? std_sum : acc_q + std_sum;
  end

  always_comb begin
    for (int l = 0; l < CH; l++) begin
      res_wide[l] = sat_round(SR_W'(res3_q[l]), FRAC_W, DATA_W);
`ifdef CONV_RELU_EN
      if (res_wide[l] < 0) res_wide[l] = '0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      ctl1_q  <= '0;
      ctl2_q  <= '0;
      acc_q   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      for (int l = 0; l < CH; l++) res3_q[l] <= '0;
    end else if (en) begin
      v1_q   <= i_valid;
      ctl1_q <= '{opc: i_opcode, first: i_first, last: i_last};
      v2_q   <= v1_q;
      ctl2_q <= ctl1_q;

      if (v2_q && ctl2_q.opc == OPC_DW) begin
        v3_q <= 1'b1;
        for (int l = 0; l < CH; l++) res3_q[l] <= lane_sum[l];
      end else if (v2_q) begin
        // Standard beat: always folds into the accumulator, emits only on last.
        acc_q     <= acc_next;
        v3_q      <= ctl2_q.last;
        res3_q[0] <= acc_next;
        for (int l = 1; l < CH; l++) res3_q[l] <= '0;
      end else begin
        v3_q <= 1'b0;
      end

      o_valid <= v3_q;
      if (v3_q) begin
        for (int l = 0; l < CH; l++) o_data[l*DATA_W +: DATA_W] <= res_wide[l][DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
module tb_conv_mac_pipe;

  localparam int CH     = 3;
  localparam int DATA_W = 10;
  localparam int FRAC_W = 9;
  localparam int ACC_W  = 26;
  localparam int BW     = CH*9*DATA_W;
  localparam int OW     = CH*DATA_W;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [BW-1:0] i_busData;
  logic [BW-1:0] i_busWeight;
  logic          i_opcode;
  logic          i_first;
  logic          i_last;
  logic          o_valid;
  logic          i_ready;
  logic [OW-1:0] o_data;

  conv_mac_pipe #(.CH(CH), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_busData   (i_busData),
    .i_busWeight (i_busWeight),
    .i_opcode    (i_opcode),
    .i_first     (i_first),
    .i_last      (i_last),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_chk  = 0;
  int            n_pass = 0;
  int            n_out  = 0;
  logic [OW-1:0] last_out;
  logic [OW-1:0] exp_q[$];
  longint        acc_m = 0;
  logic          stall_prev = 1'b0;
  logic [OW-1:0] held;

  // ---------------- reference model ----------------
  function automatic longint ref_round(input longint v);
    longint r;
    longint hi;
    longint lo;
    hi = (longint'(1) << (DATA_W-1)) - 1;
    lo = -(longint'(1) << (DATA_W-1));
    r  = v + (longint'(1) << (FRAC_W-1));
    r  = r >>> FRAC_W;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`ifdef CONV_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  function automatic longint lane_dot(input logic [BW-1:0] d, input logic [BW-1:0] w, input int l);
    longint s;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    s = 0;
    for (int t = 0; t < 9; t++) begin
      a = d[(l*9+t)*DATA_W +: DATA_W];
      b = w[(l*9+t)*DATA_W +: DATA_W];
      s = s + longint'(a) * longint'(b);
    end
    return s;
  endfunction

  function automatic longint wrap_acc(input longint v);
    logic signed [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return longint'(t);
  endfunction

  function automatic logic [OW-1:0] pack3(input longint a, input longint b, input longint c);
    logic [OW-1:0] o;
    o = '0;
    o[0*DATA_W +: DATA_W] = a[DATA_W-1:0];
    o[1*DATA_W +: DATA_W] = b[DATA_W-1:0];
    o[2*DATA_W +: DATA_W] = c[DATA_W-1:0];
    return o;
  endfunction

  task automatic model_beat();
    logic [OW-1:0] e;
    longint        s;
    e = '0;
    if (i_opcode) begin
      for (int l = 0; l < CH; l++) begin
        s = ref_round(lane_dot(i_busData, i_busWeight, l));
        e[l*DATA_W +: DATA_W] = s[DATA_W-1:0];
      end
      exp_q.push_back(e);
    end else begin
      s = 0;
      for (int l = 0; l < CH; l++) s = s + lane_dot(i_busData, i_busWeight, l);
      acc_m = wrap_acc(i_first ? s : acc_m + s);
      if (i_last) exp_q.push_back(pack3(ref_round(acc_m), 0, 0));
    end
  endtask

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_m      = 0;
      stall_prev = 1'b0;
      chk_int("reset_o_valid", int'(o_valid), 0);
      chk("reset_o_data", o_data, '0);
    end else begin
      chk_int("o_ready_rule", int'(o_ready), int'(!o_valid || i_ready));
      if (stall_prev) chk("stall_hold", o_data, held);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk_int("unexpected_output", 1, 0);
        end else begin
          chk("result", o_data, exp_q.pop_front());
        end
        last_out = o_data;
        n_out++;
      end
      stall_prev = o_valid && !i_ready;
      held       = o_data;
      if (i_valid && o_ready) model_beat();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_beat(input logic [BW-1:0] d, input logic [BW-1:0] w,
                            input logic opc, input logic f, input logic l);
    int guard;
    @(posedge clk); #1;
    i_busData = d; i_busWeight = w; i_opcode = opc; i_first = f; i_last = l;
    i_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (o_ready) break;
      guard++;
      if (guard > 100) begin
        chk_int("accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [OW-1:0] exp, input int n_before);
    int guard;
    guard = 0;
    while (n_out <= n_before && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (n_out <= n_before) chk_int({name, "_timeout"}, 1, 0);
    else chk(name, last_out, exp);
  endtask

  function automatic logic [BW-1:0] set_tap(input logic [BW-1:0] bus, input int l, input int t, input int v);
    logic [BW-1:0] b;
    logic [31:0]   vv;
    b  = bus;
    vv = v;
    b[(l*9+t)*DATA_W +: DATA_W] = vv[DATA_W-1:0];
    return b;
  endfunction

  // ---------------- main sequence ----------------
  logic [BW-1:0] d, w;
  logic [BW-1:0] bd [8];
  logic [BW-1:0] bw [8];
  int            n0, sent, cyc, guard;
  logic          saw_block;
  longint        neg_exp;

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_busData = '0; i_busWeight = '0; i_opcode = 1'b0; i_first = 1'b0; i_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_int("ready_after_reset", int'(o_ready), 1);

    // depthwise basic
    d = '0; w = '0;
    d = set_tap(d, 0, 0, 256);  w = set_tap(w, 0, 0, 256);
    d = set_tap(d, 1, 0, -256); w = set_tap(w, 1, 0, 256);
    n0 = n_out;
    drive_beat(d, w, 1'b1, 1'b0, 1'b0);
    expect_out("dw_basic", pack3(128, -128, 0), n0);
    repeat (6) @(negedge clk);
    chk_int("dw_one_pulse", n_out, n0 + 1);

    // standard single-beat window
    d = '0; w = '0;
    for (int l = 0; l < CH; l++) begin
      d = set_tap(d, l, 0, 256); w = set_tap(w, l, 0, 256);
    end
    n0 = n_out;
    drive_beat(d, w, 1'b0, 1'b1, 1'b1);
    expect_out("std_single", pack3(384, 0, 0), n0);

    // positive saturation
    d = '0; w = '0;
    for (int l = 0; l < CH; l++)
      for (int t = 0; t < 9; t++) begin
        d = set_tap(d, l, t, 511); w = set_tap(w, l, t, 511);
      end
    n0 = n_out;
    drive_beat(d, w, 1'b0, 1'b1, 1'b1);
    expect_out("sat_pos", pack3(511, 0, 0), n0);

    // negative saturation (or clamp to zero)
    for (int l = 0; l < CH; l++)
      for (int t = 0; t < 9; t++) d = set_tap(d, l, t, -512);
`ifdef CONV_RELU_EN
    neg_exp = 0;
`else
    neg_exp = -512;
`endif
    n0 = n_out;
    drive_beat(d, w, 1'b0, 1'b1, 1'b1);
    expect_out("sat_neg", pack3(neg_exp, 0, 0), n0);

    // three-beat accumulation window
    d = '0; w = '0;
    d = set_tap(d, 0, 0, 128); w = set_tap(w, 0, 0, 256);
    n0 = n_out;
    drive_beat(d, w, 1'b0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    chk_int("win_no_out_1", n_out, n0);
    drive_beat(d, w, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    chk_int("win_no_out_2", n_out, n0);
    drive_beat(d, w, 1'b0, 1'b0, 1'b1);
    expect_out("win_3beat", pack3(192, 0, 0), n0);

    // backpressure stream of 8 depthwise beats
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < CH*9; k++) begin
        bd[i][k*DATA_W +: DATA_W] = DATA_W'($urandom);
        bw[i][k*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
    sent = 0; cyc = 0; saw_block = 1'b0; n0 = n_out;
    while ((sent < 8 || n_out < n0 + 8) && cyc < 200) begin
      @(posedge clk); #1;
      i_ready = !(cyc >= 5 && cyc < 10);
      i_valid = (sent < 8);
      if (sent < 8) begin
        i_busData = bd[sent]; i_busWeight = bw[sent];
        i_opcode = 1'b1; i_first = 1'b0; i_last = 1'b0;
      end
      @(negedge clk);
      if (!o_ready) saw_block = 1'b1;
      if (i_valid && o_ready) sent++;
      cyc++;
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    chk_int("bp_count", n_out, n0 + 8);
    chk_int("bp_blocked", int'(saw_block), 1);
    chk_int("bp_queue_empty", exp_q.size(), 0);

    // reset mid-window
    d = '0; w = '0;
    d = set_tap(d, 0, 0, 256); w = set_tap(w, 0, 0, 256);
    drive_beat(d, w, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_int("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_data", o_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = n_out;
    drive_beat(d, w, 1'b0, 1'b0, 1'b1);
    expect_out("post_rst_acc", pack3(128, 0, 0), n0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      i_valid  = ($urandom_range(0, 3) != 0);
      i_ready  = ($urandom_range(0, 3) != 0);
      i_opcode = $urandom_range(0, 1) != 0;
      i_first  = ($urandom_range(0, 2) == 0);
      i_last   = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < CH*9; k++) begin
        i_busData[k*DATA_W +: DATA_W]   = DATA_W'($urandom);
        i_busWeight[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk_int("rand_drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
